ahb_lite_master: RTL and testbench
==================================

# ahb_lite_master

AHB-Lite initiator that accepts single-word read/write commands on a valid/ready port and issues them as pipelined NONSEQ transfers on the AHB bus. It is the bus-driving counterpart of `sram_control`, the AHB responder. It replaces bench-level pin driving with a synthesizable master that honours HREADY wait states and the two-cycle HRESP error. Responses (read data, error flag) are returned in command order on a response pulse.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- FIFO_DEPTH, 4, command FIFO entries (power of two, ≥2)

- HCLK  in  1  bus clock, all logic on rising edge
- HRESETn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command FIFO not full
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  byte address; bits [1:0] ignored, driven as 0
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_write  out  1  echo of command type
- rsp_rdata  out  DATA_W  HRDATA captured for reads, 0 for writes
- rsp_err  out  1  transfer ended with HRESP=ERROR
- HADDR  out  ADDR_W  AHB address
- HWRITE  out  1  AHB direction
- HTRANS  out  2  IDLE(00) or NONSEQ(10) only
- HSIZE  out  3  constant 3'b010 (word)
- HWDATA  out  DATA_W  write data, data phase
- HRDATA  in  DATA_W  read data
- HREADY  in  1  transfer complete / ready
- HRESP  in  1  0=OKAY, 1=ERROR
- busy  out  1  FIFO, address slot or data slot non-empty

## Operation
- Command handshake: push when cmd_valid && cmd_ready. No bypass; a command is visible at the FIFO head the cycle after the push.
- Address slot (states A_EMPTY, A_ACTIVE, A_CANCEL):
  - A_EMPTY pops the FIFO head whenever the FIFO is non-empty, regardless of HREADY, and moves to A_ACTIVE.
  - A_ACTIVE drives HTRANS=NONSEQ with HADDR/HWRITE held stable until a cycle with HREADY=1.
- Data slot (D_EMPTY, D_ACTIVE): on HREADY=1, the address-slot command moves into the data slot; the address slot simultaneously refills from the FIFO or goes A_EMPTY (HTRANS=IDLE).
- HWDATA is driven from the data slot and held through wait states.
- Completion: a cycle with D_ACTIVE and HREADY=1 retires the data slot. rsp_valid goes high the next cycle with rsp_err=HRESP and rsp_rdata=HRDATA (reads).
- Error, cycle 1 (D_ACTIVE, HRESP=1, HREADY=0):
  - An A_ACTIVE command moves to A_CANCEL and HTRANS drops to IDLE; HADDR/HWRITE are retained.
  - The cancelled command is not consumed. It re-issues as NONSEQ in the cycle after the error completes.
- HRESP=1 with HREADY=1 in the first error cycle is a protocol violation; the block treats it as a normal completion with rsp_err=1.
- Responses are returned in issue order. The block applies no response backpressure.

## Timing
- Reset values: HTRANS=00, HADDR=0, HWRITE=0, HWDATA=0, HSIZE=010, rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_err=0, busy=0, cmd_ready=1. FIFO and both slots are empty.
- Latency with zero wait states: push at N, NONSEQ at N+2, data phase at N+3, rsp_valid at N+4.
- Throughput: one transfer per cycle with HREADY=1.
- Each HREADY=0 cycle in the data phase adds one cycle.
- Capacity: FIFO_DEPTH + 1 commands are accepted while HREADY=0 (FIFO plus address slot).
- Simultaneous push and pop on a full FIFO: the pop frees space next cycle. cmd_ready is computed from registered count only.
- HRESETn assertion mid-transfer asynchronously clears all state and outputs to reset values. In-flight commands are dropped and produce no response.

## Structure
- Add to `ahb_pkg`:
  - `htrans_t` enum (IDLE, BUSY, NONSEQ, SEQ)
  - HSIZE_WORD, HRESP_OKAY, HRESP_ERROR constants
  - `ahb_cmd_t` struct {write, addr, wdata}
  - slot-state enums
- Sub-module `ahb_cmd_fifo`: parameterized synchronous FIFO of `ahb_cmd_t` with full, empty, and count outputs and async active-low reset.

## Test plan
1. Reset: hold HRESETn=0 → HTRANS=00, rsp_valid=0, cmd_ready=1, busy=0.
2. Single write: addr 0x4, data 0xDEADBEEF, HREADY=1.
   - Required: HTRANS=10, HADDR=0x4, HWRITE=1 at N+2; HWDATA=0xDEADBEEF at N+3; rsp_valid with rsp_write=1, rsp_err=0 at N+4.
3. Back-to-back traffic: ten writes to addresses 0–4, then ten reads; responder returns data = addr+0x100.
   - Required: NONSEQ on consecutive cycles; read responses arrive in order with matching data.
4. Wait states: HREADY=0 for 2 cycles during a write data phase with a read queued.
   - Required: HADDR/HWRITE/HTRANS of the read and HWDATA of the write stay stable; the response is delayed by 2 cycles.
5. Error: read at 0x8 answered with HRESP=1/HREADY=0, then HRESP=1/HREADY=1, with a write to 0xC queued.
   - Required: HTRANS=IDLE in error cycle 1; rsp_err=1 for the read; the write to 0xC re-issues as NONSEQ in the next cycle.
6. Full and reset: HREADY=0, push 6 commands with FIFO_DEPTH=4.
   - Required: 5 accepted, cmd_ready=0 on the 6th.
   - Then assert HRESETn=0 mid-stall → HTRANS=00 immediately; no rsp_valid after release.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and constants for the initiator and its command FIFO.
// Command fields are sized to the widest supported bus; narrower buses cast in/out.
package ahb_pkg;

    localparam int unsigned AHB_ADDR_W = 32;
    localparam int unsigned AHB_DATA_W = 32;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic       HRESP_OKAY  = 1'b0;
    localparam logic       HRESP_ERROR = 1'b1;

    typedef struct packed {
        logic                  write;
        logic [AHB_ADDR_W-1:0] addr;
        logic [AHB_DATA_W-1:0] wdata;
    } ahb_cmd_t;

    typedef enum logic [1:0] {
        A_EMPTY,
        A_ACTIVE,
        A_CANCEL
    } addr_state_t;

    typedef enum logic {
        D_EMPTY,
        D_ACTIVE
    } data_state_t;

endpackage

// File: rtl/ahb_cmd_fifo.sv
// Synchronous command FIFO; full/empty/count all derive from the registered count.
module ahb_cmd_fifo
    import ahb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  ahb_cmd_t                 wr_data,
    input  logic                     pop,
    output ahb_cmd_t                 rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);

    ahb_cmd_t      mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: queued single-word commands issued as pipelined NONSEQ
// transfers, with in-order responses and two-cycle ERROR cancellation.
module ahb_lite_master
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] HADDR,
    output logic              HWRITE,
    output logic [1:0]        HTRANS,
    output logic [2:0]        HSIZE,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP,
    output logic              busy
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    ahb_cmd_t              push_cmd, fifo_head;
    logic                  fifo_full, fifo_empty, push, pop;
    logic [CW-1:0]         fifo_count;

    addr_state_t           a_state_q, a_state_d;
    ahb_cmd_t              a_cmd_q, a_cmd_d;
    data_state_t           d_state_q, d_state_d;
    logic                  d_write_q, d_write_d;
    logic [AHB_DATA_W-1:0] d_wdata_q, d_wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  err_first, addr_done, retire;

    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && cmd_ready;

    always_comb begin
        push_cmd       = '0;
        push_cmd.write = cmd_write;
        push_cmd.addr  = AHB_ADDR_W'(cmd_addr & ~ADDR_W'(3));
        push_cmd.wdata = AHB_DATA_W'(cmd_wdata);
    end

    ahb_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .push    (push),
        .wr_data (push_cmd),
        .pop     (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign err_first = (d_state_q == D_ACTIVE) && (HRESP == HRESP_ERROR) && !HREADY;
    assign addr_done = (a_state_q == A_ACTIVE) && HREADY;
    assign retire    = (d_state_q == D_ACTIVE) && HREADY;

    always_comb begin
        a_state_d = a_state_q;
        a_cmd_d   = a_cmd_q;
        pop       = 1'b0;
        unique case (a_state_q)
            A_EMPTY: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    a_cmd_d   = fifo_head;
                    a_state_d = A_ACTIVE;
                end
            end
            A_ACTIVE: begin
                if (err_first) begin
                    a_state_d = A_CANCEL;
                end else if (HREADY) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        a_cmd_d = fifo_head;
                    end else begin
                        a_state_d = A_EMPTY;
                    end
                end
            end
            // Cancelled command keeps HADDR/HWRITE and re-issues once the error completes.
            A_CANCEL: begin
                if (HREADY) a_state_d = A_ACTIVE;
            end
            default: a_state_d = A_EMPTY;
        endcase
    end

    always_comb begin
        d_state_d = d_state_q;
        d_write_d = d_write_q;
        d_wdata_d = d_wdata_q;
        if (addr_done) begin
            d_state_d = D_ACTIVE;
            d_write_d = a_cmd_q.write;
            d_wdata_d = a_cmd_q.wdata;
        end else if (HREADY) begin
            d_state_d = D_EMPTY;
        end
    end

    always_comb begin
        rsp_valid_d = retire;
        rsp_write_d = retire && d_write_q;
        rsp_err_d   = retire && (HRESP == HRESP_ERROR);
        rsp_rdata_d = (retire && !d_write_q) ? HRDATA : '0;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            a_state_q   <= A_EMPTY;
            a_cmd_q     <= '0;
            d_state_q   <= D_EMPTY;
            d_write_q   <= 1'b0;
            d_wdata_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            a_state_q   <= a_state_d;
            a_cmd_q     <= a_cmd_d;
            d_state_q   <= d_state_d;
            d_write_q   <= d_write_d;
            d_wdata_q   <= d_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // NONSEQ is withdrawn combinationally in the first ERROR cycle.
    assign HTRANS = ((a_state_q == A_ACTIVE) && !err_first) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR  = ADDR_W'(a_cmd_q.addr);
    assign HWRITE = a_cmd_q.write;
    assign HSIZE  = HSIZE_WORD;
    assign HWDATA = DATA_W'(d_wdata_q);

    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    assign busy = (fifo_count != '0) || (a_state_q != A_EMPTY) || (d_state_q != D_EMPTY);

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master with a small responder returning addr+0x100.
module tb_ahb_lite_master;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_write, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic        HWRITE, HREADY, HRESP, busy;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    int unsigned cyc = 0;
    int unsigned ns_cnt, ns_first, ns_last;
    logic        dp_valid;
    logic [31:0] dp_addr;

    typedef struct {
        logic        write;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;
    rsp_t rsp_q[$];

    always #5 HCLK = ~HCLK;

    ahb_lite_master #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .FIFO_DEPTH (4)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .HADDR     (HADDR),
        .HWRITE    (HWRITE),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .busy      (busy)
    );

    always @(negedge HCLK) begin
        if (rsp_valid) rsp_q.push_back('{rsp_write, rsp_rdata, rsp_err});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one cycle; the responder tracks the data-phase address across wait states.
    task automatic tick();
        logic        take;
        logic [31:0] a;
        take = HRESETn && (HTRANS == 2'b10) && HREADY;
        a    = HADDR;
        @(posedge HCLK);
        #1;
        cyc++;
        if (HREADY) begin
            dp_valid = take;
            dp_addr  = a;
        end
        if (take) begin
            if (ns_cnt == 0) ns_first = cyc;
            ns_last = cyc;
            ns_cnt++;
        end
        HRDATA = dp_valid ? dp_addr + 32'h100 : 32'h0;
    endtask

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int unsigned acc;
        HRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        HRDATA    = '0;
        HREADY    = 1'b1;
        HRESP     = 1'b0;
        dp_valid  = 1'b0;
        dp_addr   = '0;
        ns_cnt    = 0;
        ns_first  = 0;
        ns_last   = 0;

        // Reset state
        repeat (3) tick();
        chk("rst_htrans", 32'(HTRANS), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_hsize", 32'(HSIZE), 32'h2);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hwdata", HWDATA, 32'h0);
        HRESETn = 1'b1;
        tick();

        // Single write, zero wait states
        send(1'b1, 32'h4, 32'hDEADBEEF);
        chk("sw_n1_htrans", 32'(HTRANS), 32'h0);
        tick();
        chk("sw_n2_htrans", 32'(HTRANS), 32'h2);
        chk("sw_n2_haddr", HADDR, 32'h4);
        chk("sw_n2_hwrite", 32'(HWRITE), 32'h1);
        tick();
        chk("sw_n3_hwdata", HWDATA, 32'hDEADBEEF);
        tick();
        chk("sw_n4_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("sw_n4_rsp_write", 32'(rsp_write), 32'h1);
        chk("sw_n4_rsp_err", 32'(rsp_err), 32'h0);
        chk("sw_n4_rsp_rdata", rsp_rdata, 32'h0);
        tick();
        chk("sw_n5_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("sw_n5_busy", 32'(busy), 32'h0);

        // Back-to-back: ten writes then ten reads over word addresses 0..4
        rsp_q.delete();
        ns_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            send((i < 10) ? 1'b1 : 1'b0, 32'((i % 5) * 4), 32'h1000 + 32'(i));
        end
        repeat (4) tick();
        chk("b2b_nonseq_count", ns_cnt, 32'd20);
        chk("b2b_nonseq_span", ns_last - ns_first + 1, 32'd20);
        chk("b2b_rsp_count", 32'(rsp_q.size()), 32'd20);
        for (int i = 0; i < 20 && i < rsp_q.size(); i++) begin
            chk($sformatf("b2b_rsp%0d_write", i), 32'(rsp_q[i].write), (i < 10) ? 32'h1 : 32'h0);
            chk($sformatf("b2b_rsp%0d_rdata", i), rsp_q[i].rdata,
                (i < 10) ? 32'h0 : 32'((i % 5) * 4) + 32'h100);
            chk($sformatf("b2b_rsp%0d_err", i), 32'(rsp_q[i].err), 32'h0);
        end

        // Wait states: two HREADY=0 cycles in the write data phase, read queued
        send(1'b1, 32'h10, 32'hA5A50001);
        send(1'b0, 32'h17, 32'h0);
        chk("ws_c2_htrans", 32'(HTRANS), 32'h2);
        chk("ws_c2_haddr", HADDR, 32'h10);
        tick();
        for (int k = 0; k < 3; k++) begin
            HREADY = (k == 2);
            #1;
            chk($sformatf("ws_k%0d_htrans", k), 32'(HTRANS), 32'h2);
            chk($sformatf("ws_k%0d_haddr", k), HADDR, 32'h14);
            chk($sformatf("ws_k%0d_hwrite", k), 32'(HWRITE), 32'h0);
            chk($sformatf("ws_k%0d_hwdata", k), HWDATA, 32'hA5A50001);
            if (k > 0) chk($sformatf("ws_k%0d_rsp_valid", k), 32'(rsp_valid), 32'h0);
            tick();
        end
        chk("ws_wr_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("ws_wr_rsp_write", 32'(rsp_write), 32'h1);
        tick();
        chk("ws_rd_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("ws_rd_rsp_write", 32'(rsp_write), 32'h0);
        chk("ws_rd_rsp_rdata", rsp_rdata, 32'h114);
        tick();

        // Two-cycle ERROR on a read with a write queued behind it
        send(1'b0, 32'h8, 32'h0);
        send(1'b1, 32'hC, 32'h0C0C0C0C);
        chk("err_rd_htrans", 32'(HTRANS), 32'h2);
        chk("err_rd_haddr", HADDR, 32'h8);
        tick();
        HRESP  = 1'b1;
        HREADY = 1'b0;
        #1;
        chk("err_e1_htrans", 32'(HTRANS), 32'h0);
        chk("err_e1_haddr", HADDR, 32'hC);
        tick();
        HREADY = 1'b1;
        #1;
        chk("err_e2_htrans", 32'(HTRANS), 32'h0);
        chk("err_e2_haddr", HADDR, 32'hC);
        chk("err_e2_hwrite", 32'(HWRITE), 32'h1);
        tick();
        HRESP = 1'b0;
        #1;
        chk("err_reissue_htrans", 32'(HTRANS), 32'h2);
        chk("err_reissue_haddr", HADDR, 32'hC);
        chk("err_reissue_hwrite", 32'(HWRITE), 32'h1);
        chk("err_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("err_rsp_err", 32'(rsp_err), 32'h1);
        chk("err_rsp_write", 32'(rsp_write), 32'h0);
        tick();
        chk("err_wr_hwdata", HWDATA, 32'h0C0C0C0C);
        chk("err_gap_rsp_valid", 32'(rsp_valid), 32'h0);
        tick();
        chk("err_wr_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("err_wr_rsp_write", 32'(rsp_write), 32'h1);
        chk("err_wr_rsp_err", 32'(rsp_err), 32'h0);
        repeat (2) tick();

        // Capacity under a stalled bus, then asynchronous reset mid-stall
        HREADY = 1'b0;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            cmd_valid = 1'b1;
            cmd_write = 1'b1;
            cmd_addr  = 32'h40 + 32'(k * 4);
            cmd_wdata = 32'h5000 + 32'(k);
            #1;
            if (cmd_ready) acc++;
            if (k == 5) chk("full_cmd_ready_6th", 32'(cmd_ready), 32'h0);
            tick();
        end
        cmd_valid = 1'b0;
        chk("full_accepted", acc, 32'd5);
        chk("full_htrans", 32'(HTRANS), 32'h2);
        chk("full_haddr", HADDR, 32'h40);
        chk("full_busy", 32'(busy), 32'h1);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("arst_htrans", 32'(HTRANS), 32'h0);
        chk("arst_haddr", HADDR, 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_cmd_ready", 32'(cmd_ready), 32'h1);
        rsp_q.delete();
        repeat (2) tick();
        HREADY  = 1'b1;
        HRESETn = 1'b1;
        repeat (6) tick();
        chk("arst_no_rsp", 32'(rsp_q.size()), 32'h0);
        chk("arst_idle_htrans", 32'(HTRANS), 32'h0);
        chk("arst_idle_busy", 32'(busy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
